// File: rtl/prog_fifo_pkg.sv
// Shared types for the programmable-threshold FIFO.
package prog_fifo_pkg;

   typedef enum logic {MODE_STD, MODE_FWFT} fifo_mode_e;

endpackage

// File: rtl/prog_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module prog_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fifo.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// fill level, registered ack/overflow/underflow pulses and STD or FWFT read path.
module prog_fifo
   import prog_fifo_pkg::*;
#(
   parameter int         WIDTH = 8,
   parameter int         DEPTH = 16,
   parameter fifo_mode_e MODE  = MODE_STD,
   localparam int        AW    = $clog2(DEPTH),
   localparam int        LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   input  logic [LW-1:0]    af_thresh,
   input  logic [LW-1:0]    ae_thresh,
   output logic [WIDTH-1:0] dout,
   output logic             rd_valid,
   output logic             wr_ack,
   output logic             overflow,
   output logic             underflow,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    level
);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] rd_data;

   // Acceptance is decided from the registered level, so a write at full is
   // rejected even if a read frees a slot in the same cycle.
   assign full   = (level == LW'(DEPTH));
   assign empty  = (level == '0);
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Threshold corner cases fall out of the plain compares since level <= DEPTH.
   assign almost_full  = (level >= af_thresh);
   assign almost_empty = (level <= ae_thresh);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         if (wr_acc && !rd_acc)      level <= level + LW'(1);
         else if (rd_acc && !wr_acc) level <= level - LW'(1);
         wr_ack    <= wr_acc;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   prog_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   generate
      if (MODE == MODE_FWFT) begin : g_fwft
         assign dout     = rd_data;
         assign rd_valid = !empty;
      end else begin : g_std
         always_ff @(posedge clk) begin
            if (rst) begin
               dout     <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) dout <= rd_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_prog_fifo.sv
// Directed bench: STD and FWFT instances share one stimulus stream.
module tb_prog_fifo;
   import prog_fifo_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst, wr_en, rd_en;
   logic [WIDTH-1:0] din;
   logic [LW-1:0]    af_thresh, ae_thresh;

   logic [WIDTH-1:0] s_dout, f_dout;
   logic             s_rd_valid, s_wr_ack, s_overflow, s_underflow, s_full, s_empty, s_af, s_ae;
   logic             f_rd_valid, f_wr_ack, f_overflow, f_underflow, f_full, f_empty, f_af, f_ae;
   logic [LW-1:0]    s_level, f_level;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   prog_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(MODE_STD)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .dout(s_dout), .rd_valid(s_rd_valid), .wr_ack(s_wr_ack),
      .overflow(s_overflow), .underflow(s_underflow), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .level(s_level)
   );

   prog_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(MODE_FWFT)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .dout(f_dout), .rd_valid(f_rd_valid), .wr_ack(f_wr_ack),
      .overflow(f_overflow), .underflow(f_underflow), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .level(f_level)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      ncmp++;
      assert (got === want) else begin
         nerr++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
      af_thresh = '0; ae_thresh = LW'(3);
      step();
      step();
      rst = 1'b0;

      // reset state
      chk("rst_level", s_level, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_full", s_full, 0);
      chk("rst_ae", s_ae, 1);
      chk("rst_af_thr0", s_af, 1);
      chk("rst_ack", s_wr_ack, 0);
      chk("rst_ovf", s_overflow, 0);
      chk("rst_udf", s_underflow, 0);
      chk("rst_dout", s_dout, 0);
      chk("rst_std_rv", s_rd_valid, 0);
      chk("rst_fwft_rv", f_rd_valid, 0);
      af_thresh = LW'(12);
      #1;
      chk("rst_af_thr12", s_af, 0);

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; din = WIDTH'(i);
         step();
         chk("fill_ack", s_wr_ack, 1);
         chk("fill_level", s_level, i + 1);
         chk("fill_af", s_af, (i + 1 >= 12) ? 1 : 0);
         chk("fill_ae", s_ae, (i + 1 <= 3) ? 1 : 0);
         chk("fill_fwft_head", f_dout, 0);
         chk("fill_fwft_rv", f_rd_valid, 1);
      end
      chk("fill_full", s_full, 1);

      // write at full
      din = 8'h55;
      step();
      chk("ovf_pulse", s_overflow, 1);
      chk("ovf_ack", s_wr_ack, 0);
      chk("ovf_level", s_level, 16);
      wr_en = 1'b0;
      step();
      chk("ovf_clear", s_overflow, 0);

      // drain
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_dout", s_dout, i);
         chk("drain_rv", s_rd_valid, 1);
         chk("drain_level", s_level, 15 - i);
         chk("drain_fwft_rv", f_rd_valid, (i < 15) ? 1 : 0);
         if (i < 15) chk("drain_fwft_dout", f_dout, i + 1);
      end
      chk("drain_empty", s_empty, 1);

      // read at empty
      step();
      chk("udf_pulse", s_underflow, 1);
      chk("udf_dout_held", s_dout, 8'h0F);
      chk("udf_rv", s_rd_valid, 0);
      rd_en = 1'b0;
      step();
      chk("udf_clear", s_underflow, 0);

      // level 8, then 20 cycles of simultaneous read/write across the wrap
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; din = WIDTH'(8'h20 + i);
         step();
      end
      chk("half_level", s_level, 8);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; din = WIDTH'(8'h28 + i);
         step();
         chk("sim_level", s_level, 8);
         chk("sim_dout", s_dout, 8'h20 + i);
         chk("sim_fwft_dout", f_dout, 8'h21 + i);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("thr_af_off", s_af, 0);
      af_thresh = LW'(5);
      #1;
      chk("thr_af_now", s_af, 1);
      af_thresh = LW'(12);

      // fill to full, then simultaneous request at full
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; din = WIDTH'(8'h3C + i);
         step();
      end
      chk("full2", s_full, 1);
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h99;
      step();
      chk("full_sim_ovf", s_overflow, 1);
      chk("full_sim_ack", s_wr_ack, 0);
      chk("full_sim_level", s_level, 15);
      chk("full_sim_dout", s_dout, 8'h34);
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rd_en = 1'b0;
      chk("pre_rst_level", s_level, 10);
      chk("pre_rst_dout", s_dout, 8'h39);

      // reset mid-operation with a write pending
      rst = 1'b1; wr_en = 1'b1; din = 8'h77;
      step();
      rst = 1'b0; wr_en = 1'b0;
      chk("mid_rst_level", s_level, 0);
      chk("mid_rst_empty", s_empty, 1);
      chk("mid_rst_ack", s_wr_ack, 0);
      chk("mid_rst_fwft_level", f_level, 0);
      chk("mid_rst_dout", s_dout, 0);

      // FWFT single word
      wr_en = 1'b1; din = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("fwft_dout", f_dout, 8'hA5);
      chk("fwft_rv", f_rd_valid, 1);
      chk("fwft_ack", f_wr_ack, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("fwft_pop_empty", f_empty, 1);
      chk("fwft_pop_rv", f_rd_valid, 0);
      chk("post_rst_std_dout", s_dout, 8'hA5);
      chk("post_rst_std_rv", s_rd_valid, 1);
      step();
      chk("post_rst_rv_clear", s_rd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
